// File: rtl/reqrsp_mem_responder_pkg.sv
// Shared types for the reqrsp memory responder: AMO opcodes, the default
// reqrsp request/response structs and the latency-pipeline entry.
package reqrsp_mem_responder_pkg;

    localparam int unsigned PkgAddrWidth = 32;
    localparam int unsigned PkgDataWidth = 32;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [PkgAddrWidth-1:0]   addr;
        logic                      write;
        amo_op_e                   amo;
        logic [PkgDataWidth-1:0]   data;
        logic [PkgDataWidth/8-1:0] strb;
    } req_chan_t;

    typedef struct packed {
        logic [PkgDataWidth-1:0] data;
        logic                    error;
    } rsp_chan_t;

    typedef struct packed {
        logic      q_valid;
        req_chan_t q;
        logic      p_ready;
    } req_t;

    typedef struct packed {
        logic      q_ready;
        logic      p_valid;
        rsp_chan_t p;
    } rsp_t;

    typedef struct packed {
        logic valid;
        logic write;
        logic error;
    } pipe_entry_t;

endpackage

// File: rtl/reqrsp_mem_responder_fifo.sv
// Small synchronous FIFO with optional fall-through: when empty, a pushed
// word is visible on rdata in the same cycle and can be popped directly.
module reqrsp_mem_responder_fifo #(
    parameter bit          FallThrough = 1'b1,
    parameter int unsigned Depth       = 2,
    parameter type         dtype       = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  dtype wdata,
    input  logic pop,
    output dtype rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    dtype                mem_q [Depth];
    logic [PtrWidth-1:0] rptr_q, wptr_q;
    logic [CntWidth-1:0] count_q;
    logic                bypass, do_write, do_read;

    assign bypass   = FallThrough && (count_q == '0);
    assign full     = (count_q == CntWidth'(Depth));
    assign empty    = (count_q == '0) && !(FallThrough && push);
    assign rdata    = bypass ? wdata : mem_q[rptr_q];
    // A word that falls through and is popped in the same cycle is never stored.
    assign do_write = push && !full && !(bypass && pop);
    assign do_read  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_write) begin
                wptr_q <= (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + PtrWidth'(1);
            end
            if (do_read) begin
                rptr_q <= (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + PtrWidth'(1);
            end
            if (do_write && !do_read) begin
                count_q <= count_q + CntWidth'(1);
            end else if (do_read && !do_write) begin
                count_q <= count_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/reqrsp_mem_responder.sv
// Terminating reqrsp responder: turns requests into fixed-latency SRAM
// accesses and returns one in-order response per accepted request.
module reqrsp_mem_responder
    import reqrsp_mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth  = PkgAddrWidth,
    parameter int unsigned DataWidth  = PkgDataWidth,
    parameter type         req_t      = reqrsp_mem_responder_pkg::req_t,
    parameter type         rsp_t      = reqrsp_mem_responder_pkg::rsp_t,
    parameter type         rsp_chan_t = reqrsp_mem_responder_pkg::rsp_chan_t,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned Depth      = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  req_t                   reqrsp_req_i,
    output rsp_t                   reqrsp_rsp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                credit_ok, is_amo, q_ready, q_hs, p_hs;
    pipe_entry_t         pipe_q [MemLatency];
    pipe_entry_t         pipe_in, pipe_out;
    rsp_chan_t           fifo_in, fifo_out;
    logic                fifo_push, fifo_full, fifo_empty;

    assign is_amo    = (reqrsp_req_i.q.amo != AMONone);
    assign credit_ok = (cnt_q < CntWidth'(Depth));
    assign mem_req_o = reqrsp_req_i.q_valid && credit_ok && !is_amo;
    assign q_ready   = reqrsp_req_i.q_valid && credit_ok && (is_amo || mem_gnt_i);
    assign q_hs      = q_ready;
    assign p_hs      = !fifo_empty && reqrsp_req_i.p_ready;

    assign mem_addr_o  = reqrsp_req_i.q.addr;
    assign mem_we_o    = reqrsp_req_i.q.write;
    assign mem_wdata_o = reqrsp_req_i.q.data;
    assign mem_be_o    = reqrsp_req_i.q.write ? reqrsp_req_i.q.strb : '1;

    always_comb begin
        reqrsp_rsp_o         = '0;
        reqrsp_rsp_o.q_ready = q_ready;
        reqrsp_rsp_o.p_valid = !fifo_empty;
        reqrsp_rsp_o.p       = fifo_out;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (q_hs && !p_hs) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (p_hs && !q_hs) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = 1'b1;
        pipe_in.write = reqrsp_req_i.q.write;
        pipe_in.error = is_amo;
    end

    // Stage MemLatency-1 lines up with mem_rdata_i of the same access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MemLatency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= q_hs ? pipe_in : '0;
            for (int unsigned i = 1; i < MemLatency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_out  = pipe_q[MemLatency-1];
    assign fifo_push = pipe_out.valid;

    always_comb begin
        fifo_in       = '0;
        fifo_in.error = pipe_out.valid && pipe_out.error;
        if (pipe_out.valid && !pipe_out.write && !pipe_out.error) begin
            fifo_in.data = mem_rdata_i;
        end
    end

    reqrsp_mem_responder_fifo #(
        .FallThrough (1'b1),
        .Depth       (Depth),
        .dtype       (rsp_chan_t)
    ) i_rsp_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (fifo_push),
        .wdata (fifo_in),
        .pop   (p_hs),
        .rdata (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full));
    assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CntWidth'(Depth));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (reqrsp_req_i.q_valid && !q_ready) |=> (reqrsp_req_i.q_valid && $stable(reqrsp_req_i.q)));

endmodule
